// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register block for the custom IP core.
// Provides the operand/start interface, result capture, sticky status flags and a level irq.
module custom_axi_ip_regs #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
   input  logic                    s_awvalid_i,
   output logic                    s_awready_o,
   input  logic [DATA_WIDTH-1:0]   s_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
   input  logic                    s_wvalid_i,
   output logic                    s_wready_o,
   output logic [1:0]              s_bresp_o,
   output logic                    s_bvalid_o,
   input  logic                    s_bready_i,
   input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
   input  logic                    s_arvalid_i,
   output logic                    s_arready_o,
   output logic [DATA_WIDTH-1:0]   s_rdata_o,
   output logic [1:0]              s_rresp_o,
   output logic                    s_rvalid_o,
   input  logic                    s_rready_i,
   output logic [DATA_WIDTH-1:0]   ipreg_data_o,
   output logic                    enable_o,
   input  logic [DATA_WIDTH-1:0]   ipreg_data_i,
   input  logic [1:0]              status_i,
   output logic                    irq_o
);

   localparam int unsigned IdxW = ADDR_WIDTH - 2;

   localparam logic [1:0] StatIdle   = 2'd0;
   localparam logic [1:0] StatDone   = 2'd2;
   localparam logic [1:0] StatError  = 2'd3;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   logic                  awready_q, awready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  irq_en_q, irq_en_d;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  rej_q, rej_d;
   logic                  enable_q, enable_d;
   logic                  irq_q, irq_d;
   logic [1:0]            prev_status_q;

   logic                  wr_hs, rd_hs;
   logic [IdxW-1:0]       wr_idx, rd_idx;
   logic                  wr_in_map, rd_in_map;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_addr_lsb;

   assign wr_hs     = awready_q & s_awvalid_i & s_wvalid_i;
   assign rd_hs     = arready_q & s_arvalid_i;
   assign wr_idx    = s_awaddr_i[ADDR_WIDTH-1:2];
   assign rd_idx    = s_araddr_i[ADDR_WIDTH-1:2];
   assign wr_in_map = wr_idx < IdxW'(4);
   assign rd_in_map = rd_idx < IdxW'(4);

   // Byte offset within a word carries no meaning for this map.
   assign unused_addr_lsb = ^{s_awaddr_i[1:0], s_araddr_i[1:0]};

   always_comb begin
      rd_word = '0;
      if (rd_in_map) begin
         unique case (rd_idx[1:0])
            2'd0: rd_word[1]   = irq_en_q;
            2'd1: rd_word      = data_in_q;
            2'd2: rd_word      = data_out_q;
            2'd3: rd_word[4:0] = {rej_q, err_q, done_q, status_i};
         endcase
      end
   end

   always_comb begin
      // Ready is a one-cycle pulse; it never re-arms while a response is outstanding.
      awready_d = s_awvalid_i & s_wvalid_i & ~bvalid_q & ~awready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (bvalid_q && s_bready_i) begin
         bvalid_d = 1'b0;
      end
      if (wr_hs) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_in_map ? RespOkay : RespSlvErr;
      end

      arready_d = s_arvalid_i & ~rvalid_q & ~arready_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      if (rvalid_q && s_rready_i) begin
         rvalid_d = 1'b0;
      end
      if (rd_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_in_map ? RespOkay : RespSlvErr;
         rdata_d  = rd_word;
      end

      irq_en_d   = irq_en_q;
      data_in_d  = data_in_q;
      data_out_d = data_out_q;
      done_d     = done_q;
      err_d      = err_q;
      rej_d      = rej_q;
      enable_d   = 1'b0;

      if (wr_hs && wr_in_map) begin
         unique case (wr_idx[1:0])
            2'd0: begin
               if (s_wstrb_i[0]) begin
                  irq_en_d = s_wdata_i[1];
                  if (s_wdata_i[0]) begin
                     if (status_i == StatIdle && !enable_q) begin
                        enable_d = 1'b1;
                     end else begin
                        rej_d = 1'b1;
                     end
                  end
               end
            end
            2'd1: begin
               for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                  if (s_wstrb_i[b]) begin
                     data_in_d[8*b +: 8] = s_wdata_i[8*b +: 8];
                  end
               end
            end
            2'd2: ;
            2'd3: begin
               if (s_wstrb_i[0]) begin
                  if (s_wdata_i[2]) done_d = 1'b0;
                  if (s_wdata_i[3]) err_d  = 1'b0;
                  if (s_wdata_i[4]) rej_d  = 1'b0;
               end
            end
         endcase
      end

      // Hardware set events come after the W1C so a coincident set wins.
      if (status_i == StatDone && prev_status_q != StatDone) begin
         data_out_d = ipreg_data_i;
         done_d     = 1'b1;
      end
      if (status_i == StatError && prev_status_q != StatError) begin
         err_d = 1'b1;
      end

      irq_d = irq_en_q & (done_q | err_q | rej_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         awready_q     <= 1'b0;
         bvalid_q      <= 1'b0;
         bresp_q       <= RespOkay;
         arready_q     <= 1'b0;
         rvalid_q      <= 1'b0;
         rresp_q       <= RespOkay;
         rdata_q       <= '0;
         irq_en_q      <= 1'b0;
         data_in_q     <= '0;
         data_out_q    <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         rej_q         <= 1'b0;
         enable_q      <= 1'b0;
         irq_q         <= 1'b0;
         prev_status_q <= StatIdle;
      end else begin
         awready_q     <= awready_d;
         bvalid_q      <= bvalid_d;
         bresp_q       <= bresp_d;
         arready_q     <= arready_d;
         rvalid_q      <= rvalid_d;
         rresp_q       <= rresp_d;
         rdata_q       <= rdata_d;
         irq_en_q      <= irq_en_d;
         data_in_q     <= data_in_d;
         data_out_q    <= data_out_d;
         done_q        <= done_d;
         err_q         <= err_d;
         rej_q         <= rej_d;
         enable_q      <= enable_d;
         irq_q         <= irq_d;
         prev_status_q <= status_i;
      end
   end

   assign s_awready_o  = awready_q;
   assign s_wready_o   = awready_q;
   assign s_bvalid_o   = bvalid_q;
   assign s_bresp_o    = bresp_q;
   assign s_arready_o  = arready_q;
   assign s_rvalid_o   = rvalid_q;
   assign s_rresp_o    = rresp_q;
   assign s_rdata_o    = rdata_q;
   assign ipreg_data_o = data_in_q;
   assign enable_o     = enable_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// Self-checking bench for custom_axi_ip_regs: directed scenarios plus randomized traffic
// compared against a register-level behavioural model.
module tb_custom_axi_ip_regs;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StDone = 2'd2;
   localparam logic [1:0] StErr  = 2'd3;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [4:0]  s_awaddr_i = '0;
   logic        s_awvalid_i = 1'b0;
   logic        s_awready_o;
   logic [31:0] s_wdata_i = '0;
   logic [3:0]  s_wstrb_i = '0;
   logic        s_wvalid_i = 1'b0;
   logic        s_wready_o;
   logic [1:0]  s_bresp_o;
   logic        s_bvalid_o;
   logic        s_bready_i = 1'b0;
   logic [4:0]  s_araddr_i = '0;
   logic        s_arvalid_i = 1'b0;
   logic        s_arready_o;
   logic [31:0] s_rdata_o;
   logic [1:0]  s_rresp_o;
   logic        s_rvalid_o;
   logic        s_rready_i = 1'b0;
   logic [31:0] ipreg_data_o;
   logic        enable_o;
   logic [31:0] ipreg_data_i = '0;
   logic [1:0]  status_i = StIdle;
   logic        irq_o;

   always #5 clk_i = ~clk_i;

   custom_axi_ip_regs #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .s_awaddr_i  (s_awaddr_i),
      .s_awvalid_i (s_awvalid_i),
      .s_awready_o (s_awready_o),
      .s_wdata_i   (s_wdata_i),
      .s_wstrb_i   (s_wstrb_i),
      .s_wvalid_i  (s_wvalid_i),
      .s_wready_o  (s_wready_o),
      .s_bresp_o   (s_bresp_o),
      .s_bvalid_o  (s_bvalid_o),
      .s_bready_i  (s_bready_i),
      .s_araddr_i  (s_araddr_i),
      .s_arvalid_i (s_arvalid_i),
      .s_arready_o (s_arready_o),
      .s_rdata_o   (s_rdata_o),
      .s_rresp_o   (s_rresp_o),
      .s_rvalid_o  (s_rvalid_o),
      .s_rready_i  (s_rready_i),
      .ipreg_data_o(ipreg_data_o),
      .enable_o    (enable_o),
      .ipreg_data_i(ipreg_data_i),
      .status_i    (status_i),
      .irq_o       (irq_o)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned en_cnt = 0;
   logic        irq_at_acc;

   always @(negedge clk_i) if (enable_o) en_cnt <= en_cnt + 1;

   // Behavioural register model
   logic        m_irq_en, m_done, m_err, m_rej;
   logic [31:0] m_data_in, m_data_out;
   logic [1:0]  m_status;
   int unsigned m_pulses = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_irq_en = 0; m_done = 0; m_err = 0; m_rej = 0;
      m_data_in = '0; m_data_out = '0; m_status = StIdle;
   endtask

   task automatic model_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] live_st, output logic [1:0] resp,
                              output bit pulse);
      int unsigned idx;
      idx = 32'(addr) / 4;
      pulse = 0;
      resp = (idx >= 4) ? 2'b10 : 2'b00;
      if (idx == 0 && s[0]) begin
         m_irq_en = d[1];
         if (d[0]) begin
            if (live_st == StIdle) begin
               pulse = 1;
               m_pulses++;
            end else begin
               m_rej = 1;
            end
         end
      end else if (idx == 1) begin
         for (int b = 0; b < 4; b++) if (s[b]) m_data_in[8*b +: 8] = d[8*b +: 8];
      end else if (idx == 3 && s[0]) begin
         if (d[2]) m_done = 0;
         if (d[3]) m_err = 0;
         if (d[4]) m_rej = 0;
      end
   endtask

   task automatic model_status(input logic [1:0] st, input logic [31:0] res);
      if (st == StDone && m_status != StDone) begin
         m_data_out = res;
         m_done = 1;
      end
      if (st == StErr && m_status != StErr) m_err = 1;
      m_status = st;
   endtask

   function automatic logic [33:0] model_read(input logic [4:0] addr);
      int unsigned idx;
      idx = 32'(addr) / 4;
      case (idx)
         0: return {2'b00, 32'({m_irq_en, 1'b0})};
         1: return {2'b00, m_data_in};
         2: return {2'b00, m_data_out};
         3: return {2'b00, 32'({m_rej, m_err, m_done, m_status})};
         default: return {2'b10, 32'h0};
      endcase
   endfunction

   task automatic check_irq(input string tag);
      check_eq(tag, 32'(irq_o), 32'(m_irq_en & (m_done | m_err | m_rej)));
   endtask

   task automatic set_status(input logic [1:0] st, input logic [31:0] res);
      @(negedge clk_i);
      status_i = st;
      ipreg_data_i = res;
      model_status(st, res);
      repeat (2) @(negedge clk_i);
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] s,
                            input bit st_en, input logic [1:0] st, input logic [31:0] res);
      logic [1:0] exp_resp;
      bit pulse;
      int n;
      @(negedge clk_i);
      s_awaddr_i = addr; s_wdata_i = d; s_wstrb_i = s;
      s_awvalid_i = 1; s_wvalid_i = 1;
      n = 0;
      while (!(s_awready_o && s_wready_o) && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (n == 20) begin
         check_eq("wr_accept_timeout", 32'(s_awready_o & s_wready_o), 32'd1);
         s_awvalid_i = 0; s_wvalid_i = 0;
         return;
      end
      if (st_en) begin
         status_i = st;
         ipreg_data_i = res;
      end
      model_write(addr, d, s, st_en ? st : m_status, exp_resp, pulse);
      if (st_en) model_status(st, res);
      @(negedge clk_i);
      s_awvalid_i = 0; s_wvalid_i = 0;
      check_eq("enable_after_accept", 32'(enable_o), 32'(pulse));
      if (pulse) check_eq("data_at_enable", ipreg_data_o, m_data_in);
      irq_at_acc = irq_o;
      s_bready_i = 1;
      n = 0;
      while (!s_bvalid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("bresp", 32'(s_bresp_o), 32'(exp_resp));
      @(negedge clk_i);
      s_bready_i = 0;
      check_eq("bvalid_clear", 32'(s_bvalid_o), 32'd0);
      check_eq("ipreg_data", ipreg_data_o, m_data_in);
   endtask

   task automatic axi_read(input logic [4:0] addr, input int unsigned dly, input string tag);
      logic [33:0] exp;
      int n;
      exp = model_read(addr);
      @(negedge clk_i);
      s_araddr_i = addr;
      s_arvalid_i = 1;
      n = 0;
      while (!s_arready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (n == 20) begin
         check_eq({tag, "_ar_timeout"}, 32'(s_arready_o), 32'd1);
         s_arvalid_i = 0;
         return;
      end
      @(negedge clk_i);
      s_arvalid_i = 0;
      n = 0;
      while (!s_rvalid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      repeat (dly) @(negedge clk_i);
      check_eq({tag, "_rdata"}, s_rdata_o, exp[31:0]);
      check_eq({tag, "_rresp"}, 32'(s_rresp_o), 32'(exp[33:32]));
      s_rready_i = 1;
      @(negedge clk_i);
      s_rready_i = 0;
      check_eq({tag, "_rvalid_clear"}, 32'(s_rvalid_o), 32'd0);
   endtask

   initial begin
      int n;
      int unsigned en0;
      logic [1:0] r;
      bit p;
      bit seen;
      model_reset();
      irq_at_acc = 0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1;
      check_eq("rst_awready", 32'(s_awready_o), 32'd0);
      check_eq("rst_bvalid", 32'(s_bvalid_o), 32'd0);
      check_eq("rst_rvalid", 32'(s_rvalid_o), 32'd0);
      check_eq("rst_enable", 32'(enable_o), 32'd0);
      check_eq("rst_ipreg", ipreg_data_o, 32'd0);
      check_eq("rst_irq", 32'(irq_o), 32'd0);
      for (int a = 0; a < 4; a++) axi_read(5'(a * 4), 0, "rst_reg");

      // Byte strobes and unmapped region
      axi_write(5'h04, 32'h0, 4'hF, 0, StIdle, 0);
      axi_write(5'h04, 32'hFFFF_FFFF, 4'b0101, 0, StIdle, 0);
      axi_read(5'h04, 1, "strb_data_in");
      check_eq("strb_ipreg", ipreg_data_o, 32'h00FF_00FF);
      axi_write(5'h14, 32'hDEAD_BEEF, 4'hF, 0, StIdle, 0);
      axi_read(5'h14, 0, "unmapped");
      axi_write(5'h08, 32'h1234_5678, 4'hF, 0, StIdle, 0);
      axi_read(5'h08, 0, "data_out_ro");

      // Start, core completion and irq
      axi_write(5'h04, 32'h0000_0041, 4'hF, 0, StIdle, 0);
      en0 = en_cnt;
      axi_write(5'h00, 32'h3, 4'hF, 0, StIdle, 0);
      set_status(StBusy, 32'h0);
      set_status(StDone, 32'h42);
      check_eq("start_pulse_count", en_cnt - en0, 32'd1);
      axi_read(5'h08, 0, "result");
      axi_read(5'h0C, 2, "status_done");
      check_eq("irq_on_done", 32'(irq_o), 32'd1);
      set_status(StIdle, 32'h0);
      axi_read(5'h0C, 0, "status_idle");
      axi_write(5'h0C, 32'h4, 4'h1, 0, StIdle, 0);
      check_eq("irq_latency", 32'(irq_at_acc), 32'd1);
      check_eq("irq_cleared", 32'(irq_o), 32'd0);

      // Start rejected while busy
      set_status(StBusy, 32'h0);
      en0 = en_cnt;
      axi_write(5'h00, 32'h3, 4'h1, 0, StIdle, 0);
      check_eq("rej_no_pulse", en_cnt - en0, 32'd0);
      axi_read(5'h0C, 0, "status_rej");
      check_irq("irq_rej");
      set_status(StIdle, 32'h0);
      axi_write(5'h0C, 32'h1C, 4'h1, 0, StIdle, 0);

      // Write backpressure: second write waits for the B handshake
      @(negedge clk_i);
      s_awaddr_i = 5'h04; s_wdata_i = 32'h1111_1111; s_wstrb_i = 4'hF;
      s_awvalid_i = 1; s_wvalid_i = 1;
      n = 0;
      while (!s_awready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("bp_first_accept", 32'(s_awready_o), 32'd1);
      model_write(5'h04, 32'h1111_1111, 4'hF, m_status, r, p);
      @(negedge clk_i);
      s_wdata_i = 32'h2222_2222;
      seen = 0;
      repeat (5) begin
         if (s_awready_o || s_wready_o) seen = 1;
         @(negedge clk_i);
      end
      check_eq("bp_ready_blocked", 32'(seen), 32'd0);
      check_eq("bp_bvalid_held", 32'(s_bvalid_o), 32'd1);
      check_eq("bp_first_bresp", 32'(s_bresp_o), 32'd0);
      s_bready_i = 1;
      @(negedge clk_i);
      s_bready_i = 0;
      n = 0;
      while (!s_awready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("bp_second_accept", 32'(s_awready_o & s_wready_o), 32'd1);
      model_write(5'h04, 32'h2222_2222, 4'hF, m_status, r, p);
      @(negedge clk_i);
      s_awvalid_i = 0; s_wvalid_i = 0; s_bready_i = 1;
      n = 0;
      while (!s_bvalid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("bp_second_bresp", 32'(s_bresp_o), 32'd0);
      @(negedge clk_i);
      s_bready_i = 0;
      axi_read(5'h04, 0, "bp_data_in");

      // DONE rising on the same edge as its W1C: set wins
      axi_write(5'h0C, 32'h4, 4'h1, 1, StDone, 32'h0000_ABCD);
      axi_read(5'h0C, 0, "w1c_vs_set");
      axi_read(5'h08, 0, "w1c_vs_set_result");
      set_status(StIdle, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         int unsigned op;
         logic [4:0] a;
         op = $urandom_range(0, 9);
         a = 5'({3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))});
         if (op < 4) begin
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), 0, StIdle, 0);
         end else if (op < 7) begin
            axi_read(a, $urandom_range(0, 3), "rand_read");
         end else begin
            set_status(2'($urandom_range(0, 3)), $urandom);
         end
         check_irq("rand_irq");
      end
      check_eq("pulse_total", en_cnt, m_pulses);

      // Reset with a read response pending
      set_status(StIdle, 32'h0);
      @(negedge clk_i);
      s_araddr_i = 5'h04;
      s_arvalid_i = 1;
      n = 0;
      while (!s_arready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      @(negedge clk_i);
      s_arvalid_i = 0;
      check_eq("rst_pending_rvalid", 32'(s_rvalid_o), 32'd1);
      rst_ni = 0;
      #1;
      check_eq("rst_drop_rvalid", 32'(s_rvalid_o), 32'd0);
      check_eq("rst_drop_rdata", s_rdata_o, 32'd0);
      check_eq("rst_drop_ipreg", ipreg_data_o, 32'd0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1;
      for (int a = 0; a < 4; a++) axi_read(5'(a * 4), 0, "post_rst_reg");
      check_irq("post_rst_irq");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/custom_axi_ip_regs.md
Name: custom_axi_ip_regs

Overview:
AXI4-Lite subordinate register block that drives the register-to-hardware interface of the custom IP core. Software writes an operand and a START command. The block issues a one-cycle enable to the core and tracks the core's status. When the core reaches DONE, the block captures its result into a readable register. It also keeps sticky completion/reject flags and a level interrupt.

Parameters:
DATA_WIDTH, 32, AXI data width and IP data width; only 32 supported
ADDR_WIDTH, 5, AXI byte address width; 8 word slots, 4 implemented

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
s_awaddr_i  input  ADDR_WIDTH  write address
s_awvalid_i  input  1  write address valid
s_awready_o  output  1  write address ready
s_wdata_i  input  32  write data
s_wstrb_i  input  4  write byte strobes
s_wvalid_i  input  1  write data valid
s_wready_o  output  1  write data ready
s_bresp_o  output  2  write response (00 OKAY, 10 SLVERR)
s_bvalid_o  output  1  write response valid
s_bready_i  input  1  write response ready
s_araddr_i  input  ADDR_WIDTH  read address
s_arvalid_i  input  1  read address valid
s_arready_o  output  1  read address ready
s_rdata_o  output  32  read data
s_rresp_o  output  2  read response
s_rvalid_o  output  1  read data valid
s_rready_i  input  1  read data ready
ipreg_data_o  output  32  operand to core (DATA_IN register)
enable_o  output  1  one-cycle start pulse to core
ipreg_data_i  input  32  result from core
status_i  input  2  core status, custom_axi_ip_pkg::status_e (IDLE=0, BUSY=1, DONE=2, ERROR=3)
irq_o  output  1  level interrupt

Behaviour:
- Reset: all AXI ready/valid outputs 0, bresp/rresp/rdata 0, ipreg_data_o 0, enable_o 0, irq_o 0; all registers 0; prev_status = IDLE.
- Register map, word aligned, addr[1:0] ignored:
  - 0x00 CTRL: bit0 START (write-1 pulses, reads 0); bit1 IRQ_EN (RW); other bits read 0.
  - 0x04 DATA_IN: RW, drives ipreg_data_o.
  - 0x08 DATA_OUT: RO; writes are ignored and return OKAY.
  - 0x0C STATUS: [1:0] live status_i (RO); bit2 DONE sticky (W1C); bit3 ERR sticky (W1C); bit4 START_REJ sticky (W1C).
  - 0x10–0x1C: reads return 0 with SLVERR; writes have no effect and return SLVERR.
- Write channel:
  - awready/wready assert together for exactly one cycle when awvalid && wvalid && !bvalid. No write is accepted while a B response is pending.
  - Register update happens on the accept edge. bvalid rises the next cycle and holds until bready.
  - WSTRB gates byte lanes for DATA_IN and CTRL[7:0]. For STATUS, W1C applies only to lane 0.
- Read channel:
  - arready pulses for one cycle when arvalid && !rvalid. rdata/rresp are registered on accept; rvalid rises the next cycle and holds, with stable data, until rready.
- Read and write accepted in the same cycle proceed independently; the read returns the pre-write value.
- START: a write of 1 to CTRL bit0 with wstrb[0] set:
  - If status_i == IDLE and enable_o is not already pending, enable_o = 1 for exactly the cycle after accept.
  - Otherwise no pulse, and START_REJ is set.
  - DATA_IN written in an earlier transaction is stable when enable_o asserts.
- Completion capture: prev_status registers status_i every cycle.
  - When status_i == DONE && prev_status != DONE: DATA_OUT <= ipreg_data_i and DONE sticky is set.
  - When status_i == ERROR && prev_status != ERROR: ERR sticky is set and DATA_OUT is unchanged.
- Sticky set and W1C on the same cycle: set wins.
- irq_o = IRQ_EN & (DONE | ERR | START_REJ), registered; one cycle latency after the flag updates.
- Reset mid-transaction: all channels return to idle immediately; a pending B or R is dropped.

Test Plan:
- Reset, then read all four registers -> CTRL=0, DATA_IN=0, DATA_OUT=0, STATUS=0x0; OKAY; irq_o=0.
- Write DATA_IN=0x0000_0041, CTRL=0x3; core model goes IDLE->BUSY->DONE returning 0x42 -> enable_o high exactly 1 cycle; DATA_OUT reads 0x42; STATUS=0x6 while DONE (0x4 after return to IDLE); irq_o=1. Write STATUS=0x4 -> irq_o=0 after one cycle.
- Write CTRL START while status_i=BUSY -> no enable_o pulse; STATUS bit4 set; B response OKAY.
- Write DATA_IN=0xFFFF_FFFF with wstrb=0b0101 over prior 0x0 -> reads 0x00FF_00FF; write and read to 0x14 -> SLVERR; rdata=0.
- Hold bready=0 for 5 cycles after a write and issue a second write -> awready/wready stay 0 until the B handshake completes; then the second write is accepted.
- Same-cycle DONE rising edge and W1C of DONE -> DONE bit remains 1; assert rst_ni low during pending rvalid -> rvalid=0 immediately.
